// File: rtl/mult_div_unit_if.sv
// Handshake bundle between control and the mult/div unit.
// Operands and starts flow in, HI/LO and status flow back.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start_mult;
  logic             start_div;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start_mult, start_div, a_in, b_in,
    input  hi, lo, busy, done, div_zero
  );

  modport slave (
    input  start_mult, start_div, a_in, b_in,
    output hi, lo, busy, done, div_zero
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit owning HI/LO.
// Radix-2 Booth multiply, restoring divide, one bit per cycle.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clck,
  input  logic             reset_n,
  mult_div_unit_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE, MULT, DIV, FIX, FIN
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   m;
  logic [2*WIDTH+1:0] p;
  logic [WIDTH-1:0]   r, q, bmag;
  logic               sign_q, sign_r;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q, dz_q, dz_pend;

  logic               accept, go_mult, go_div;
  logic               b_zero, last;
  logic               busy, done_nxt, dz_nxt;

  assign accept  = (state == IDLE) || (state == FIN);
  assign go_mult = accept && bus.start_mult;
  assign go_div  = accept && bus.start_div && !bus.start_mult;
  assign b_zero  = (bus.b_in == '0);
  assign last    = (cnt == CNT_W'(WIDTH-1));

  // Booth step on a WIDTH+1 accumulator so -2^(W-1) stays exact
  logic [WIDTH:0]     m_ext, acc, sum;
  logic [2*WIDTH+1:0] p_step;

  assign m_ext = {m[WIDTH-1], m};
  assign acc   = p[2*WIDTH+1:WIDTH+1];

  always_comb begin
    sum = acc;
    unique case (1'b1)
      p[1:0] == 2'b01: sum = acc + m_ext;
      p[1:0] == 2'b10: sum = acc - m_ext;
      default:         sum = acc;
    endcase
  end

  assign p_step = {sum[WIDTH], sum, p[WIDTH:1]};

  logic [WIDTH:0]   rs, trial;
  logic [WIDTH-1:0] r_step, q_step;
  logic [WIDTH-1:0] a_abs, b_abs;

  assign rs     = {r, q[WIDTH-1]};
  assign trial  = rs - {1'b0, bmag};
  assign r_step = trial[WIDTH] ? rs[WIDTH-1:0]
                               : trial[WIDTH-1:0];
  assign q_step = {q[WIDTH-2:0], ~trial[WIDTH]};

  assign a_abs = bus.a_in[WIDTH-1] ? -bus.a_in : bus.a_in;
  assign b_abs = bus.b_in[WIDTH-1] ? -bus.b_in : bus.b_in;

  always_ff @(posedge clck or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, FIN: begin
        if (go_mult)                state_nxt = MULT;
        else if (go_div && !b_zero) state_nxt = DIV;
        else                        state_nxt = IDLE;
      end
      MULT:    state_nxt = last ? FIN : MULT;
      DIV:     state_nxt = last ? FIX : DIV;
      FIX:     state_nxt = FIN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == MULT) || (state == DIV)
            || (state == FIX);
    done_nxt = (state == FIN) || dz_pend;
    dz_nxt   = dz_pend;
  end

  always_ff @(posedge clck or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      m       <= '0;
      p       <= '0;
      r       <= '0;
      q       <= '0;
      bmag    <= '0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      dz_pend <= 1'b0;
    end else begin
      done_q  <= done_nxt;
      dz_q    <= dz_nxt;
      dz_pend <= go_div && b_zero;
      if (go_mult) begin
        m   <= bus.a_in;
        p   <= {{(WIDTH+1){1'b0}}, bus.b_in, 1'b0};
        cnt <= '0;
      end else if (go_div && !b_zero) begin
        q      <= a_abs;
        bmag   <= b_abs;
        r      <= '0;
        sign_q <= bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1];
        sign_r <= bus.a_in[WIDTH-1];
        cnt    <= '0;
      end else if (state == MULT) begin
        p   <= p_step;
        cnt <= cnt + CNT_W'(1);
        if (last) begin
          hi_q <= p_step[2*WIDTH:WIDTH+1];
          lo_q <= p_step[WIDTH:1];
        end
      end else if (state == DIV) begin
        r   <= r_step;
        q   <= q_step;
        cnt <= cnt + CNT_W'(1);
      end else if (state == FIX) begin
        lo_q <= sign_q ? -q : q;
        hi_q <= sign_r ? -r : r;
      end
    end
  end

  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.busy     = busy;
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table,
// corner sequences, and random ops against an arithmetic model.
module tb_mult_div_unit;

  logic clck = 1'b0;
  logic reset_n = 1'b0;

  always #5 clck = ~clck;

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clck    (clck),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  typedef struct {
    bit          is_div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
    bit          edz;
  } vec_t;

  vec_t        tbl [10];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_op(input bit is_div,
                        input logic [31:0] a, b,
                        output logic [31:0] rh, rl,
                        output bit dz, output int lat,
                        output bit bsy);
    @(posedge clck); #1;
    bus.start_mult = !is_div;
    bus.start_div  = is_div;
    bus.a_in = a;
    bus.b_in = b;
    @(posedge clck); #1;
    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;
    bus.a_in = $urandom;
    bus.b_in = $urandom;
    lat = 0;
    bsy = 1'b0;
    for (int i = 0; i < 60; i++) begin
      bsy |= bus.busy;
      @(posedge clck); #1;
      lat++;
      if (bus.done) break;
    end
    rh  = bus.hi;
    rl  = bus.lo;
    dz  = bus.div_zero;
  endtask

  task automatic exec(string nm, bit is_div,
                      logic [31:0] a, b, eh, el, bit edz);
    logic [31:0] rh, rl;
    bit dz, bsy, d;
    int lat, elat;
    run_op(is_div, a, b, rh, rl, dz, lat, bsy);
    d = bus.done;
    elat = edz ? 1 : (is_div ? 34 : 33);
    chk({nm, ".done"}, 64'(d), 64'(1));
    chk({nm, ".lat"}, 64'(lat), 64'(elat));
    chk({nm, ".hi"}, 64'(rh), 64'(eh));
    chk({nm, ".lo"}, 64'(rl), 64'(el));
    chk({nm, ".dz"}, 64'(dz), 64'(edz));
    chk({nm, ".busy_seen"}, 64'(bsy), 64'(!edz));
    chk({nm, ".busy_end"}, 64'(bus.busy), 64'(0));
    @(posedge clck); #1;
    chk({nm, ".done_1cyc"}, 64'(bus.done), 64'(0));
    mhi = eh;
    mlo = el;
  endtask

  task automatic model(bit is_div, logic [31:0] a, b,
                       output logic [31:0] eh, el,
                       output bit edz);
    longint la, lb, pr, qq, rr;
    la  = longint'($signed(a));
    lb  = longint'($signed(b));
    edz = 1'b0;
    if (!is_div) begin
      pr = la * lb;
      eh = pr[63:32];
      el = pr[31:0];
    end else if (b == 0) begin
      eh  = mhi;
      el  = mlo;
      edz = 1'b1;
    end else begin
      qq = la / lb;
      rr = la % lb;
      eh = rr[31:0];
      el = qq[31:0];
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, b, eh, el, rh, rl;
    bit edz, dz, isd;
    int ndone, flat, t;

    tbl[0] = '{0, 32'd7, 32'hFFFFFFFD,
               32'hFFFFFFFF, 32'hFFFFFFEB, 0};
    tbl[1] = '{0, 32'h80000000, 32'h80000000,
               32'h40000000, 32'h00000000, 0};
    tbl[2] = '{1, 32'd5, 32'd0,
               32'h40000000, 32'h00000000, 1};
    tbl[3] = '{1, 32'hFFFFFFF9, 32'd2,
               32'hFFFFFFFF, 32'hFFFFFFFD, 0};
    tbl[4] = '{1, 32'd7, 32'hFFFFFFFE,
               32'h00000001, 32'hFFFFFFFD, 0};
    tbl[5] = '{1, 32'h80000000, 32'hFFFFFFFF,
               32'h00000000, 32'h80000000, 0};
    tbl[6] = '{0, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'h00000000, 32'h00000001, 0};
    tbl[7] = '{1, 32'd100, 32'd7,
               32'd2, 32'd14, 0};
    tbl[8] = '{0, 32'h7FFFFFFF, 32'h7FFFFFFF,
               32'h3FFFFFFF, 32'h00000001, 0};
    tbl[9] = '{1, 32'd0, 32'd5,
               32'd0, 32'd0, 0};

    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;
    bus.a_in = '0;
    bus.b_in = '0;
    repeat (3) @(posedge clck);
    #1;
    chk("rst.hi", 64'(bus.hi), 64'(0));
    chk("rst.lo", 64'(bus.lo), 64'(0));
    chk("rst.busy", 64'(bus.busy), 64'(0));
    chk("rst.done", 64'(bus.done), 64'(0));
    chk("rst.dz", 64'(bus.div_zero), 64'(0));
    @(negedge clck);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++)
      exec($sformatf("vec%0d", i), tbl[i].is_div,
           tbl[i].a, tbl[i].b, tbl[i].eh,
           tbl[i].el, tbl[i].edz);

    // overflow divide with an ignored mult mid-flight
    @(posedge clck); #1;
    bus.start_div = 1'b1;
    bus.a_in = 32'h80000000;
    bus.b_in = 32'hFFFFFFFF;
    @(posedge clck); #1;
    bus.start_div = 1'b0;
    bus.a_in = 32'd3;
    bus.b_in = 32'd3;
    ndone = 0;
    flat = 0;
    rh = '0;
    rl = '0;
    dz = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clck); #1;
      bus.start_mult = (c == 10);
      if (bus.done) begin
        ndone++;
        if (flat == 0) begin
          flat = c;
          rh = bus.hi;
          rl = bus.lo;
          dz = bus.div_zero;
        end
      end
    end
    chk("ign.ndone", 64'(ndone), 64'(1));
    chk("ign.lat", 64'(flat), 64'(34));
    chk("ign.hi", 64'(rh), 64'(0));
    chk("ign.lo", 64'(rl), 64'h80000000);
    chk("ign.dz", 64'(dz), 64'(0));
    chk("ign.hold_lo", 64'(bus.lo), 64'h80000000);

    // async reset in the middle of a multiply
    @(posedge clck); #1;
    bus.start_mult = 1'b1;
    bus.a_in = 32'd5;
    bus.b_in = 32'd9;
    @(posedge clck); #1;
    bus.start_mult = 1'b0;
    repeat (14) @(posedge clck);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst.hi", 64'(bus.hi), 64'(0));
    chk("arst.lo", 64'(bus.lo), 64'(0));
    chk("arst.busy", 64'(bus.busy), 64'(0));
    chk("arst.done", 64'(bus.done), 64'(0));
    repeat (2) @(posedge clck);
    #2;
    reset_n = 1'b1;
    mhi = '0;
    mlo = '0;
    exec("arst.3x4", 0, 32'd3, 32'd4, 32'd0, 32'd12, 0);

    for (int n = 0; n < 40; n++) begin
      isd = 1'($urandom_range(0, 1));
      t = $urandom_range(0, 7);
      a = (t == 7) ? 32'h80000000 : $urandom;
      t = $urandom_range(0, 7);
      if (t == 0)      b = '0;
      else if (t < 3)  b = 32'($urandom_range(0, 15)) - 32'd8;
      else             b = $urandom;
      model(isd, a, b, eh, el, edz);
      exec($sformatf("rnd%0d", n), isd, a, b, eh, el, edz);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
